// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forward-select codes,
// hazard FSM states, stage destination payload and the default mult/div latency.
package mips_pkg;

   localparam int unsigned REG_W                  = 5;
   localparam int unsigned FWD_W                  = 2;
   localparam int unsigned BUSY_W                 = 4;
   localparam int unsigned STATS_W                = 32;
   localparam int unsigned MULDIV_LATENCY_DEFAULT = 4;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LOAD_STALL  = 2'd1,
      MULDIV_WAIT = 2'd2
   } hazard_state_t;

   // Destination fields leaving one pipeline register.
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             rf_enable;
   } stage_dst_t;

   // A stage matches a source when it writes that register and it is not $0.
   function automatic logic reg_match(input stage_dst_t dst, input logic [REG_W-1:0] src);
      return dst.rf_enable && (dst.rd == src) && (src != '0);
   endfunction

endpackage

// File: rtl/mips_fwd_select.sv
// Priority operand-forwarding select for one ID-stage source register;
// flags a load-use hazard instead of forwarding from a load still in EX.
module mips_fwd_select
   import mips_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             uses,
   input  stage_dst_t       ex_dst,
   input  logic             ex_load,
   input  stage_dst_t       mem_dst,
   input  stage_dst_t       wb_dst,
   output logic [FWD_W-1:0] sel_c,
   output logic             load_use_c
);

   always_comb begin
      sel_c      = FWD_RF;
      load_use_c = 1'b0;
      if (uses) begin
         if (reg_match(ex_dst, src)) begin
            if (ex_load) begin
               load_use_c = 1'b1;
            end else begin
               sel_c = FWD_EX;
            end
         end else if (reg_match(mem_dst, src)) begin
            sel_c = FWD_MEM;
         end else if (reg_match(wb_dst, src)) begin
            sel_c = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/mips_hazard_unit.sv
// Five-stage MIPS hazard unit: forwarding selects, load-use and HI/LO stalls.
// Optional stall statistics counter enabled by defining MIPS_HAZARD_STATS_EN.
module mips_hazard_unit
   import mips_pkg::*;
#(
   parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [REG_W-1:0] ID_RS,
   input  logic [REG_W-1:0] ID_RT,
   input  logic             ID_USES_RS,
   input  logic             ID_USES_RT,
   input  logic             ID_USES_HILO,
   input  logic [REG_W-1:0] EX_REG,
   input  logic             EX_RF_ENABLE,
   input  logic             EX_LOAD_INSTR,
   input  logic             EX_MULDIV,
   input  logic [REG_W-1:0] MEM_REG,
   input  logic             MEM_RF_ENABLE,
   input  logic [REG_W-1:0] WB_REG,
   input  logic             WB_RF_ENABLE,
   output logic [FWD_W-1:0] FWD_A_SEL,
   output logic [FWD_W-1:0] FWD_B_SEL,
   output logic             PC_LE,
   output logic             IF_ID_LE,
   output logic             ID_EX_BUBBLE
`ifdef MIPS_HAZARD_STATS_EN
   ,
   output logic [STATS_W-1:0] STALL_COUNT
`endif
);

   localparam logic [BUSY_W-1:0] BUSY_RELOAD = BUSY_W'(MULDIV_LATENCY - 1);

   hazard_state_t     state;
   hazard_state_t     state_nxt;
   logic [BUSY_W-1:0] busy_cnt;
   stage_dst_t        ex_dst;
   stage_dst_t        mem_dst;
   stage_dst_t        wb_dst;
   logic [FWD_W-1:0]  sel_a;
   logic [FWD_W-1:0]  sel_b;
   logic              load_use_a;
   logic              load_use_b;
   logic              load_use;
   logic              hilo_hazard;
   logic              stall;

   assign ex_dst  = '{rd: EX_REG,  rf_enable: EX_RF_ENABLE};
   assign mem_dst = '{rd: MEM_REG, rf_enable: MEM_RF_ENABLE};
   assign wb_dst  = '{rd: WB_REG,  rf_enable: WB_RF_ENABLE};

   mips_fwd_select u_fwd_rs (
      .src        (ID_RS),
      .uses       (ID_USES_RS),
      .ex_dst     (ex_dst),
      .ex_load    (EX_LOAD_INSTR),
      .mem_dst    (mem_dst),
      .wb_dst     (wb_dst),
      .sel_c      (sel_a),
      .load_use_c (load_use_a)
   );

   mips_fwd_select u_fwd_rt (
      .src        (ID_RT),
      .uses       (ID_USES_RT),
      .ex_dst     (ex_dst),
      .ex_load    (EX_LOAD_INSTR),
      .mem_dst    (mem_dst),
      .wb_dst     (wb_dst),
      .sel_c      (sel_b),
      .load_use_c (load_use_b)
   );

   // mfhi/mflo must wait while a mult/div is in EX or still owns HI/LO.
   assign load_use    = load_use_a | load_use_b;
   assign hilo_hazard = ID_USES_HILO & ((busy_cnt != '0) | EX_MULDIV);
   assign stall       = load_use | hilo_hazard;

   // HI/LO busy counter: a new mult/div always reloads, otherwise counts down to 0.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         busy_cnt <= '0;
      end else if (EX_MULDIV) begin
         busy_cnt <= BUSY_RELOAD;
      end else if (busy_cnt != '0) begin
         busy_cnt <= busy_cnt - BUSY_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Load-use wins over HI/LO when both appear in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (load_use) begin
               state_nxt = LOAD_STALL;
            end else if (hilo_hazard) begin
               state_nxt = MULDIV_WAIT;
            end
         end
         LOAD_STALL: begin
            state_nxt = hilo_hazard ? MULDIV_WAIT : RUN;
         end
         MULDIV_WAIT: begin
            if (hilo_hazard) begin
               state_nxt = MULDIV_WAIT;
            end else if (load_use) begin
               state_nxt = LOAD_STALL;
            end else begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // Reset overrides everything so a stall in flight is dropped at once.
   always_comb begin
      FWD_A_SEL    = FWD_RF;
      FWD_B_SEL    = FWD_RF;
      PC_LE        = 1'b1;
      IF_ID_LE     = 1'b1;
      ID_EX_BUBBLE = 1'b0;
      if (!Reset) begin
         if (stall) begin
            PC_LE        = 1'b0;
            IF_ID_LE     = 1'b0;
            ID_EX_BUBBLE = 1'b1;
         end else begin
            FWD_A_SEL = sel_a;
            FWD_B_SEL = sel_b;
         end
      end
   end

`ifdef MIPS_HAZARD_STATS_EN
   // Saturating count of stalled cycles.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         STALL_COUNT <= '0;
      end else if (stall && (STALL_COUNT != '1)) begin
         STALL_COUNT <= STALL_COUNT + STATS_W'(1);
      end
   end
`endif

endmodule

// File: doc/mips_hazard_unit.md
# mips_hazard_unit

Backward-direction control block of the five-stage MIPS pipeline. Consumes the destination and enable fields leaving the ID/EX, EX/MEM and MEM/WB pipeline registers, plus the source fields leaving IF/ID. Returns operand-forwarding selects to the ID-stage operand muxes (MX1/MX2) and stall/bubble controls to the PC, IF/ID and ID/EX registers. Tracks load-use stalls and multi-cycle HI/LO (mult/div) occupancy with a small state machine and a busy counter.

## Interface
- MULDIV_LATENCY, 4: cycles a mult/div occupies HI/LO after entering EX; legal range 1..15.
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- ID_RS  in  5  rs of the instruction in ID.
- ID_RT  in  5  rt of the instruction in ID.
- ID_USES_RS  in  1  ID instruction reads rs.
- ID_USES_RT  in  1  ID instruction reads rt.
- ID_USES_HILO  in  1  ID instruction reads HI or LO (mfhi/mflo).
- EX_REG  in  5  destination register of the instruction in EX.
- EX_RF_ENABLE  in  1  EX instruction writes the register file.
- EX_LOAD_INSTR  in  1  EX instruction is a load.
- EX_MULDIV  in  1  EX instruction is mult/multu/div/divu.
- MEM_REG  in  5  destination in MEM.
- MEM_RF_ENABLE  in  1  MEM instruction writes the register file.
- WB_REG  in  5  destination in WB.
- WB_RF_ENABLE  in  1  WB instruction writes the register file.
- FWD_A_SEL  out  2  MX1 select: 00 register file, 01 EX result, 10 MEM result (ALU or load data), 11 WB PW.
- FWD_B_SEL  out  2  MX2 select, same encoding, for rt.
- PC_LE  out  1  1 = PC loads, 0 = PC holds.
- IF_ID_LE  out  1  1 = IF/ID loads, 0 = IF/ID holds its contents (not cleared).
- ID_EX_BUBBLE  out  1  1 = ID/EX captures all-zero control signals this cycle.
- STALL_COUNT  out  32  present only with MIPS_HAZARD_STATS_EN.

## Operation
- Match rule: a stage matches source S when its RF_ENABLE=1, its REG==S and S!=0. Register $0 never forwards and never stalls.
- Forwarding per operand (only when the matching USES bit is 1, else 00). Priority EX(01) > MEM(10) > WB(11) > RF(00). A match against EX when EX_LOAD_INSTR=1 is not forwarded; it causes a load-use stall instead.
- Load-use hazard: EX_LOAD_INSTR=1 and EX matches a used source.
- HI/LO hazard: ID_USES_HILO=1 and busy counter != 0, or EX_MULDIV=1.
- Stall = load-use hazard OR HI/LO hazard. During a stall: PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1, and FWD selects are don't-care but driven 00.
- Busy counter (4 bits): loads MULDIV_LATENCY-1 on any cycle with EX_MULDIV=1; otherwise decrements when nonzero; saturates at 0. A new mult/div in EX reloads regardless of the current value.
- FSM states:
  - RUN: entered from reset. Goes to LOAD_STALL on a load-use hazard. Goes to MULDIV_WAIT on a HI/LO hazard with no load-use hazard.
  - LOAD_STALL: one cycle only. The load is now in MEM, so the forward select is 10. Returns to RUN, or to MULDIV_WAIT if a HI/LO hazard is present.
  - MULDIV_WAIT: holds while the HI/LO hazard persists. Returns to RUN when the counter reaches 0 or ID_USES_HILO=0.
- Load-use takes precedence over HI/LO in state selection. The stall outputs are the OR of both conditions.

## Timing
- Forward selects, PC_LE, IF_ID_LE and ID_EX_BUBBLE are combinational from the current inputs, counter and state. They are valid in the same cycle and sampled by the pipeline registers at the next posedge.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the load match from EX.
- mfhi issued directly behind a mult stalls MULDIV_LATENCY cycles in total.
- Reset: while Reset=1, all outputs are forced to PC_LE=1, IF_ID_LE=1, ID_EX_BUBBLE=0, FWD_*=00. On the next edge the state becomes RUN, the counter becomes 0 and STALL_COUNT becomes 0. Reset asserted mid-stall aborts the stall immediately.

## Configuration
- MIPS_HAZARD_STATS_EN defined: STALL_COUNT port exists. It increments by 1 on each posedge where stall=1 and Reset=0, and saturates at 32'hFFFFFFFF.
- Not defined: the port and its register are absent, and behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - the FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants;
  - the hazard FSM state typedef (RUN, LOAD_STALL, MULDIV_WAIT);
  - the default MULDIV_LATENCY.
- One sub-module, mips_fwd_select, instantiated twice (rs, rt). It is purely combinational priority matching and outputs its select plus a load-use flag.

## Test plan
- EX_REG=5, EX_RF_ENABLE=1, MEM_REG=5, MEM_RF_ENABLE=1, ID_RS=5, ID_USES_RS=1 -> FWD_A_SEL=01, no stall.
- EX load to $8, ID_RT=8, ID_USES_RT=1 -> one cycle of PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1. Next cycle state is LOAD_STALL with MEM_REG=8 -> FWD_B_SEL=10, no stall.
- ID_RS=0, with EX/MEM/WB all writing $0 (including an EX load) -> FWD_A_SEL=00, no stall.
- EX_MULDIV=1 then ID_USES_HILO=1, with MULDIV_LATENCY=4 -> stall for exactly 4 cycles, then released. STALL_COUNT=4 with the macro defined.
- Only WB_REG=3 writing, ID_RS=3 -> FWD_A_SEL=11. ID_USES_RS=0 with the same conditions -> 00.
- Reset asserted during MULDIV_WAIT -> same cycle PC_LE=1, ID_EX_BUBBLE=0. After the edge, state RUN, counter 0, STALL_COUNT 0.
